timestamp_timer_sequencer: RTL and testbench

Command-driven sequencer that owns the 16-bit Avalon slave port of the SOPC interval/timestamp timer. A single requester issues high-level commands: program period and start, stop, take a 32-bit snapshot, or clear the timeout status. The block expands each command into the exact register write/read sequence the timer requires and returns a one-cycle response. It sits between the system's control logic and the timer slave, and it is the only master on that slave.

---
 rtl/timestamp_timer_sequencer_if.sv | 42 ++++
 rtl/timestamp_timer_sequencer.sv | 170 +++++++++++++++++
 tb/tb_timestamp_timer_sequencer.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/timestamp_timer_sequencer_if.sv
// Command/response port of the timestamp timer sequencer and the
// 16-bit Avalon slave port of the interval/timestamp timer it drives.

interface timestamp_timer_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_period;
    logic        cmd_continuous;
    logic        cmd_irq_en;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        busy;

    modport master (
        output cmd_valid, cmd_op, cmd_period, cmd_continuous, cmd_irq_en,
        input  cmd_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_period, cmd_continuous, cmd_irq_en,
        output cmd_ready, rsp_valid, rsp_data, busy
    );
endinterface

interface timer_avalon_if;
    logic [2:0]  tmr_address;
    logic        tmr_chipselect;
    logic        tmr_write_n;
    logic [15:0] tmr_writedata;
    logic [15:0] tmr_readdata;

    modport master (
        output tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata,
        input  tmr_readdata
    );

    modport slave (
        input  tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata,
        output tmr_readdata
    );
endinterface

// File: rtl/timestamp_timer_sequencer.sv
// Expands PROGRAM / STOP / SNAPSHOT / CLEAR commands into the exact register
// access sequence of the interval/timestamp timer and returns a one-cycle response.

module timestamp_timer_sequencer #(
    parameter int GAP_CYCLES = 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    timestamp_timer_sequencer_if.slave   cmd,
    timer_avalon_if.master               tmr
);

    typedef enum logic [3:0] {
        S_IDLE, S_STOP_W, S_PER_L, S_PER_H, S_GAP, S_START_W,
        S_SNAP_W, S_RD_L, S_RD_H, S_RD_WAIT, S_CLR_W, S_RESP
    } state_t;

    typedef enum logic [1:0] {
        OP_PROGRAM  = 2'd0,
        OP_STOP     = 2'd1,
        OP_SNAPSHOT = 2'd2,
        OP_CLEAR    = 2'd3
    } op_t;

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    state_t      r_state, w_state_next;
    op_t         r_op;
    logic [31:0] r_period;
    logic        r_cont, r_irq_en;
    logic [3:0]  r_gap_cnt;
    logic [15:0] r_snap_lo;
    logic [31:0] r_rsp_data;
    logic        r_rsp_valid, r_cmd_ready;
    logic        r_cs, r_write_n;
    logic [2:0]  r_addr;
    logic [15:0] r_wdata;
    logic        w_cs, w_write_n;
    logic [2:0]  w_addr;
    logic [15:0] w_wdata;
    logic        w_accept;

    assign w_accept = cmd.cmd_valid && r_cmd_ready;

    // State register; bus and handshake flops are decoded from the next state
    // so each one lines up with the state it belongs to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_gap_cnt   <= 4'd0;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_cs        <= 1'b0;
            r_write_n   <= 1'b1;
            r_addr      <= 3'd0;
            r_wdata     <= 16'h0000;
        end else begin
            // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
            r_state     <= w_state_next;
            r_gap_cnt   <= (r_state == S_GAP) ? r_gap_cnt + 4'd1 : 4'd0;
            r_cmd_ready <= (w_state_next == S_IDLE);
            r_rsp_valid <= (w_state_next == S_RESP);
            r_cs        <= w_cs;
            r_write_n   <= w_write_n;
            r_addr      <= w_addr;
            r_wdata     <= w_wdata;
        end
    end

    always_comb begin
        // NOTE: default first so no path through the case infers a latch.
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (op_t'(cmd.cmd_op))
                        OP_PROGRAM:  w_state_next = S_STOP_W;
                        OP_STOP:     w_state_next = S_STOP_W;
                        OP_SNAPSHOT: w_state_next = S_SNAP_W;
                        OP_CLEAR:    w_state_next = S_CLR_W;
                    endcase
                end
            end
            S_STOP_W:  w_state_next = (r_op == OP_PROGRAM) ? S_PER_L : S_RESP;
            S_PER_L:   w_state_next = S_PER_H;
            S_PER_H:   w_state_next = S_GAP;
            S_GAP:     w_state_next = (r_gap_cnt == GAP_LAST) ? S_START_W : S_GAP;
            S_START_W: w_state_next = S_RESP;
            S_SNAP_W:  w_state_next = S_RD_L;
            S_RD_L:    w_state_next = S_RD_H;
            S_RD_H:    w_state_next = S_RD_WAIT;
            S_RD_WAIT: w_state_next = S_RESP;
            S_CLR_W:   w_state_next = S_RESP;
            S_RESP:    w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_cs      = 1'b0;
        w_write_n = 1'b1;
        w_addr    = 3'd0;
        w_wdata   = 16'h0000;
        case (w_state_next)
            S_STOP_W: begin
                w_cs = 1'b1; w_write_n = 1'b0; w_addr = 3'd1; w_wdata = 16'h0008;
            end
            S_PER_L: begin
                w_cs = 1'b1; w_write_n = 1'b0; w_addr = 3'd2; w_wdata = r_period[15:0];
            end
            S_PER_H: begin
                w_cs = 1'b1; w_write_n = 1'b0; w_addr = 3'd3; w_wdata = r_period[31:16];
            end
            S_START_W: begin
                w_cs = 1'b1; w_write_n = 1'b0; w_addr = 3'd1;
                w_wdata = {12'h000, 1'b0, 1'b1, r_cont, r_irq_en};
            end
            S_SNAP_W: begin
                w_cs = 1'b1; w_write_n = 1'b0; w_addr = 3'd4;
            end
            S_RD_L: begin
                w_cs = 1'b1; w_addr = 3'd4;
            end
            S_RD_H: begin
                w_cs = 1'b1; w_addr = 3'd5;
            end
            S_CLR_W: begin
                w_cs = 1'b1; w_write_n = 1'b0; w_addr = 3'd0;
            end
            default: ;
        endcase
    end

    // Command latch and snapshot capture. The timer's read data lags the
    // address by one cycle, so each half is sampled one state after its read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op       <= OP_PROGRAM;
            r_period   <= 32'h0000_0000;
            r_cont     <= 1'b0;
            r_irq_en   <= 1'b0;
            r_snap_lo  <= 16'h0000;
            r_rsp_data <= 32'h0000_0000;
        end else begin
            if (w_accept) begin
                r_op     <= op_t'(cmd.cmd_op);
                r_period <= cmd.cmd_period;
                r_cont   <= cmd.cmd_continuous;
                r_irq_en <= cmd.cmd_irq_en;
            end
            if (r_state == S_RD_H) begin
                r_snap_lo <= tmr.tmr_readdata;
            end
            if (w_state_next == S_RESP && r_state != S_RESP) begin
                r_rsp_data <= (r_op == OP_SNAPSHOT) ? {tmr.tmr_readdata, r_snap_lo}
                                                    : 32'h0000_0000;
            end
        end
    end

    assign cmd.cmd_ready      = r_cmd_ready;
    assign cmd.busy           = ~r_cmd_ready;
    assign cmd.rsp_valid      = r_rsp_valid;
    assign cmd.rsp_data       = r_rsp_data;
    assign tmr.tmr_chipselect = r_cs;
    assign tmr.tmr_write_n    = r_write_n;
    assign tmr.tmr_address    = r_addr;
    assign tmr.tmr_writedata  = r_wdata;

endmodule

// File: tb/tb_timestamp_timer_sequencer.sv
// Directed bench for timestamp_timer_sequencer: a vector table of commands with
// hand-computed bus sequences, plus hand-written reset and back-to-back sequences.

module tb_timestamp_timer_sequencer;

    localparam logic [20:0] IDLE_B = 21'h08_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        d_valid;
    logic [1:0]  d_op;
    logic [31:0] d_period;
    logic        d_cont, d_irq;
    logic        sel4;

    timestamp_timer_sequencer_if c1 ();
    timestamp_timer_sequencer_if c4 ();
    timer_avalon_if              t1 ();
    timer_avalon_if              t4 ();

    assign c1.cmd_valid      = d_valid & ~sel4;
    assign c4.cmd_valid      = d_valid & sel4;
    assign c1.cmd_op         = d_op;
    assign c4.cmd_op         = d_op;
    assign c1.cmd_period     = d_period;
    assign c4.cmd_period     = d_period;
    assign c1.cmd_continuous = d_cont;
    assign c4.cmd_continuous = d_cont;
    assign c1.cmd_irq_en     = d_irq;
    assign c4.cmd_irq_en     = d_irq;
    assign t4.tmr_readdata   = 16'h0000;

    timestamp_timer_sequencer #(.GAP_CYCLES(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .cmd(c1), .tmr(t1)
    );

    timestamp_timer_sequencer #(.GAP_CYCLES(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .cmd(c4), .tmr(t4)
    );

    // Observation mux over the two builds
    logic        o_ready, o_busy, o_rv;
    logic [31:0] o_rdata;
    logic [20:0] o_bus;
    assign o_ready = sel4 ? c4.cmd_ready : c1.cmd_ready;
    assign o_busy  = sel4 ? c4.busy      : c1.busy;
    assign o_rv    = sel4 ? c4.rsp_valid : c1.rsp_valid;
    assign o_rdata = sel4 ? c4.rsp_data  : c1.rsp_data;
    assign o_bus   = sel4 ? {t4.tmr_chipselect, t4.tmr_write_n, t4.tmr_address, t4.tmr_writedata}
                          : {t1.tmr_chipselect, t1.tmr_write_n, t1.tmr_address, t1.tmr_writedata};

    // Timer model: free-running down counter, snapshot latch, registered read data
    logic [31:0] tm_count = 32'h0003_E8E8;
    logic [31:0] tm_snap  = 32'h0000_0000;
    logic [15:0] tm_rd    = 16'h0000;
    assign t1.tmr_readdata = tm_rd;

    always @(posedge clk) begin
        tm_count <= tm_count - 32'd1;
        if (t1.tmr_chipselect && !t1.tmr_write_n &&
            (t1.tmr_address == 3'd4 || t1.tmr_address == 3'd5))
            tm_snap <= tm_count;
        if (t1.tmr_address == 3'd4)      tm_rd <= tm_snap[15:0];
        else if (t1.tmr_address == 3'd5) tm_rd <= tm_snap[31:16];
        else                             tm_rd <= 16'h0000;
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [20:0] wr(input logic [2:0] a, input logic [15:0] d);
        return {1'b1, 1'b0, a, d};
    endfunction

    function automatic logic [20:0] rdb(input logic [2:0] a);
        return {1'b1, 1'b1, a, 16'h0000};
    endfunction

    typedef struct {
        logic             g4;
        logic [1:0]       op;
        logic [31:0]      period;
        logic             cont;
        logic             irq;
        int               lat;
        logic [9:0][20:0] bus;
        logic             use_snap;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    task automatic run_cmd(input logic [1:0] op, input logic [31:0] per,
                           input logic cont, input logic irq,
                           output int lat, output logic [9:0][20:0] seen,
                           output logic [31:0] data, output logic busy_ok);
        int guard;
        lat = -1; data = 32'hxxxx_xxxx; busy_ok = 1'b1;
        for (int k = 0; k < 10; k++) seen[k] = 21'h1F_FFFF;
        @(negedge clk);
        guard = 0;
        while (!o_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("ready_wait", {63'd0, o_ready}, 64'd1);
        d_valid = 1'b1; d_op = op; d_period = per; d_cont = cont; d_irq = irq;
        @(posedge clk);
        #1;
        d_valid = 1'b0; d_op = ~op; d_period = ~per; d_cont = ~cont; d_irq = ~irq;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c <= 10) seen[c-1] = o_bus;
            if (o_busy == o_ready) busy_ok = 1'b0;
            if (o_rv) begin
                lat  = c;
                data = o_rdata;
                break;
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int               lat, rv_cnt, bad_cnt;
        logic [9:0][20:0] seen;
        logic [31:0]      data, exp_data;
        logic             busy_ok;
        logic [4:0][20:0] b2b_bus;
        logic [4:0]       b2b_rv, b2b_rdy;

        // ---------------- vector table ----------------
        for (int i = 0; i < NV; i++) begin
            vecs[i].g4 = 1'b0; vecs[i].use_snap = 1'b0;
            vecs[i].period = 32'h0; vecs[i].cont = 1'b0; vecs[i].irq = 1'b0;
            for (int k = 0; k < 10; k++) vecs[i].bus[k] = IDLE_B;
        end
        // PROGRAM 100000, continuous, irq
        vecs[0].op = 2'd0; vecs[0].period = 32'h0001_86A0; vecs[0].cont = 1; vecs[0].irq = 1;
        vecs[0].lat = 6;
        vecs[0].bus[0] = wr(3'd1, 16'h0008); vecs[0].bus[1] = wr(3'd2, 16'h86A0);
        vecs[0].bus[2] = wr(3'd3, 16'h0001); vecs[0].bus[4] = wr(3'd1, 16'h0007);
        // STOP
        vecs[1].op = 2'd1; vecs[1].lat = 2; vecs[1].bus[0] = wr(3'd1, 16'h0008);
        // CLEAR
        vecs[2].op = 2'd3; vecs[2].lat = 2; vecs[2].bus[0] = wr(3'd0, 16'h0000);
        // SNAPSHOT
        vecs[3].op = 2'd2; vecs[3].lat = 5; vecs[3].use_snap = 1'b1;
        vecs[3].bus[0] = wr(3'd4, 16'h0000); vecs[3].bus[1] = rdb(3'd4);
        vecs[3].bus[2] = rdb(3'd5);
        // PROGRAM period 0, one-shot, no irq (after SNAPSHOT: rsp_data back to 0)
        vecs[4].op = 2'd0; vecs[4].lat = 6;
        vecs[4].bus[0] = wr(3'd1, 16'h0008); vecs[4].bus[1] = wr(3'd2, 16'h0000);
        vecs[4].bus[2] = wr(3'd3, 16'h0000); vecs[4].bus[4] = wr(3'd1, 16'h0004);
        // PROGRAM one-shot with irq
        vecs[5].op = 2'd0; vecs[5].period = 32'hDEAD_BEEF; vecs[5].irq = 1; vecs[5].lat = 6;
        vecs[5].bus[0] = wr(3'd1, 16'h0008); vecs[5].bus[1] = wr(3'd2, 16'hBEEF);
        vecs[5].bus[2] = wr(3'd3, 16'hDEAD); vecs[5].bus[4] = wr(3'd1, 16'h0005);
        // SNAPSHOT again, later count
        vecs[6].op = 2'd2; vecs[6].lat = 5; vecs[6].use_snap = 1'b1;
        vecs[6].bus[0] = wr(3'd4, 16'h0000); vecs[6].bus[1] = rdb(3'd4);
        vecs[6].bus[2] = rdb(3'd5);
        // GAP_CYCLES=4 build: PROGRAM, continuous, no irq
        vecs[7].g4 = 1'b1; vecs[7].op = 2'd0; vecs[7].period = 32'h0001_86A0;
        vecs[7].cont = 1; vecs[7].lat = 9;
        vecs[7].bus[0] = wr(3'd1, 16'h0008); vecs[7].bus[1] = wr(3'd2, 16'h86A0);
        vecs[7].bus[2] = wr(3'd3, 16'h0001); vecs[7].bus[7] = wr(3'd1, 16'h0006);

        // ---------------- reset state ----------------
        reset_n = 1'b0; d_valid = 1'b0; d_op = 2'd0; d_period = 32'h0001_86A0;
        d_cont = 1'b1; d_irq = 1'b1; sel4 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready",  {63'd0, o_ready}, 64'd1);
        check("rst_busy",   {63'd0, o_busy},  64'd0);
        check("rst_rv",     {63'd0, o_rv},    64'd0);
        check("rst_rdata",  {32'd0, o_rdata}, 64'd0);
        check("rst_bus",    {43'd0, o_bus},   {43'd0, IDLE_B});
        check("rst_ready4", {63'd0, c4.cmd_ready}, 64'd1);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {63'd0, o_ready}, 64'd1);

        // ---------------- back-to-back with cmd_valid held high ----------------
        d_valid = 1'b1; d_op = 2'd1;
        @(posedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            b2b_bus[c] = o_bus; b2b_rv[c] = o_rv; b2b_rdy[c] = o_ready;
            if (c == 0) begin d_op = 2'd0; d_period = 32'hFFFF_FFFF; end
            if (c == 1) d_op = 2'd3;
            if (c == 3) d_valid = 1'b0;
        end
        check("b2b_bus0", {43'd0, b2b_bus[0]}, {43'd0, wr(3'd1, 16'h0008)});
        check("b2b_bus1", {43'd0, b2b_bus[1]}, {43'd0, IDLE_B});
        check("b2b_bus2", {43'd0, b2b_bus[2]}, {43'd0, IDLE_B});
        check("b2b_bus3", {43'd0, b2b_bus[3]}, {43'd0, wr(3'd0, 16'h0000)});
        check("b2b_bus4", {43'd0, b2b_bus[4]}, {43'd0, IDLE_B});
        check("b2b_rv",   {59'd0, b2b_rv},  {59'd0, 5'b10010});
        check("b2b_rdy",  {59'd0, b2b_rdy}, {59'd0, 5'b00100});
        d_period = 32'h0001_86A0;
        @(negedge clk);

        // ---------------- reset during PER_H: bus drops at once ----------------
        d_valid = 1'b1; d_op = 2'd0;
        @(posedge clk);
        #1 d_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_perh_before", {43'd0, o_bus}, {43'd0, wr(3'd3, 16'h0001)});
        reset_n = 1'b0;
        #1;
        check("rst_perh_bus",   {43'd0, o_bus},   {43'd0, IDLE_B});
        check("rst_perh_ready", {63'd0, o_ready}, 64'd1);
        @(negedge clk);
        reset_n = 1'b1;

        // ---------------- reset during GAP ----------------
        @(negedge clk);
        d_valid = 1'b1; d_op = 2'd0;
        @(posedge clk);
        #1 d_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("gap_busy", {63'd0, o_busy}, 64'd1);
        reset_n = 1'b0;
        #1;
        check("rst_gap_ready", {63'd0, o_ready}, 64'd1);
        check("rst_gap_busy",  {63'd0, o_busy},  64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        rv_cnt = 0; bad_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (o_rv) rv_cnt++;
            if (o_bus != IDLE_B || !o_ready) bad_cnt++;
        end
        check("rst_gap_no_rsp",   rv_cnt,  0);
        check("rst_gap_idle_bus", bad_cnt, 0);

        // ---------------- table-driven commands ----------------
        for (int i = 0; i < NV; i++) begin
            sel4 = vecs[i].g4;
            run_cmd(vecs[i].op, vecs[i].period, vecs[i].cont, vecs[i].irq,
                    lat, seen, data, busy_ok);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            for (int k = 0; k < vecs[i].lat; k++)
                check($sformatf("v%0d_bus_c%0d", i, k + 1), {43'd0, seen[k]}, {43'd0, vecs[i].bus[k]});
            exp_data = vecs[i].use_snap ? tm_snap : 32'h0000_0000;
            check($sformatf("v%0d_rsp_data", i), {32'd0, data}, {32'd0, exp_data});
            check($sformatf("v%0d_busy", i), {63'd0, busy_ok}, 64'd1);
            @(negedge clk);
            check($sformatf("v%0d_rv_one_cycle", i), {63'd0, o_rv}, 64'd0);
            check($sformatf("v%0d_ready_after", i), {63'd0, o_ready}, 64'd1);
            check($sformatf("v%0d_rdata_hold", i), {32'd0, o_rdata}, {32'd0, exp_data});
        end
        sel4 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
